// File: rtl/voice_mixer.sv
// Stereo voice mixer: snapshots NVOICES samples per i2s request, one MAC per voice, saturates to 16 bits.
// Optional per-voice pan is compiled in with MIXER_PAN_EN; without it both channels carry the mono sum.
module voice_mixer #(
    parameter int NVOICES = 4,
    parameter int GAIN_W  = 8,
    parameter int ACC_W   = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NVOICES*16-1:0]  voices_in,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [GAIN_W-1:0]      cfg_gain,
    input  logic [7:0]             cfg_pan,
    input  logic                   i2s_ready,
    output logic [31:0]            sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   clip,
    output logic                   overrun
);

    localparam int VW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam logic [VW-1:0] VLAST = VW'(NVOICES - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, SNAP, MAC, SAT} state_t;

    state_t                  state_q;
    logic [VW-1:0]           v_q;
    logic                    ready_d_q;
    logic                    req;
    logic [31:0]             sample_out_q;
    logic                    sample_valid_q;
    logic                    busy_q;
    logic                    clip_q;
    logic                    overrun_q;

    logic [GAIN_W-1:0]       gain_q   [NVOICES];
    logic signed [15:0]      snap_s_q [NVOICES];
    logic [GAIN_W-1:0]       snap_g_q [NVOICES];

    logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
    logic signed [15:0]      cur_s;
    logic [GAIN_W-1:0]       cur_g;
    logic signed [GAIN_W+16:0] prod;
    logic signed [23:0]      p;
    logic [16:0]             sat_l;

`ifdef MIXER_PAN_EN
    logic [7:0]              pan_q    [NVOICES];
    logic [7:0]              snap_p_q [NVOICES];
    logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
    logic [7:0]              cur_p;
    logic [8:0]              wl;
    logic signed [33:0]      pl, pr;
    logic [16:0]             sat_r;
`else
    logic                    unused_pan;
    assign unused_pan = ^cfg_pan;
`endif

    // Bit 16 flags that the clamp was active.
    function automatic logic [16:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > SMAX) return {1'b1, 16'h7fff};
        else if (a < SMIN) return {1'b1, 16'h8000};
        else return {1'b0, a[15:0]};
    endfunction

    assign req   = i2s_ready & ~ready_d_q;
    assign cur_s = snap_s_q[v_q];
    assign cur_g = snap_g_q[v_q];
    assign prod  = cur_s * $signed({1'b0, cur_g});
    assign p     = 24'(prod >>> 7);
    assign sat_l = sat16(acc_l_q);

`ifdef MIXER_PAN_EN
    assign cur_p = snap_p_q[v_q];
    assign wl    = 9'd256 - {1'b0, cur_p};
    assign pl    = p * $signed({1'b0, wl});
    assign pr    = p * $signed({2'b0, cur_p});
    assign sat_r = sat16(acc_r_q);
`endif

    always_comb begin
        acc_l_d = acc_l_q;
`ifdef MIXER_PAN_EN
        acc_r_d = acc_r_q;
        acc_l_d = acc_l_q + ACC_W'(pl >>> 8);
        acc_r_d = acc_r_q + ACC_W'(pr >>> 8);
`else
        acc_l_d = acc_l_q + ACC_W'(p);
`endif
    end

    // Config writes land immediately; the datapath only sees them at SNAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NVOICES; v++) begin
                gain_q[v] <= '0;
`ifdef MIXER_PAN_EN
                pan_q[v]  <= 8'd128;
`endif
            end
        end else begin
            for (int v = 0; v < NVOICES; v++) begin
                if (cfg_we && cfg_addr == 4'(v)) begin
                    gain_q[v] <= cfg_gain;
`ifdef MIXER_PAN_EN
                    pan_q[v]  <= cfg_pan;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            v_q            <= '0;
            ready_d_q      <= 1'b0;
            acc_l_q        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            clip_q         <= 1'b0;
            overrun_q      <= 1'b0;
            for (int v = 0; v < NVOICES; v++) begin
                snap_s_q[v] <= '0;
                snap_g_q[v] <= '0;
`ifdef MIXER_PAN_EN
                snap_p_q[v] <= 8'd128;
`endif
            end
`ifdef MIXER_PAN_EN
            acc_r_q        <= '0;
`endif
        end else begin
            ready_d_q      <= i2s_ready;
            sample_valid_q <= 1'b0;
            clip_q         <= 1'b0;
            overrun_q      <= req && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= SNAP;
                        busy_q  <= 1'b1;
                    end
                end
                SNAP: begin
                    for (int v = 0; v < NVOICES; v++) begin
                        snap_s_q[v] <= voices_in[16*v +: 16];
                        snap_g_q[v] <= gain_q[v];
`ifdef MIXER_PAN_EN
                        snap_p_q[v] <= pan_q[v];
`endif
                    end
                    acc_l_q <= '0;
`ifdef MIXER_PAN_EN
                    acc_r_q <= '0;
`endif
                    v_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_l_q <= acc_l_d;
`ifdef MIXER_PAN_EN
                    acc_r_q <= acc_r_d;
`endif
                    v_q     <= v_q + 1'b1;
                    if (v_q == VLAST) state_q <= SAT;
                end
                SAT: begin
`ifdef MIXER_PAN_EN
                    sample_out_q <= {sat_l[15:0], sat_r[15:0]};
                    clip_q       <= sat_l[16] | sat_r[16];
`else
                    sample_out_q <= {sat_l[15:0], sat_l[15:0]};
                    clip_q       <= sat_l[16];
`endif
                    sample_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign clip         = clip_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer; expected values are hand-computed for both
// the pan build (MIXER_PAN_EN) and the mono default build.
module tb_voice_mixer;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NV*16-1:0] voices_in = '0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [7:0]    cfg_gain = '0;
    logic [7:0]    cfg_pan = '0;
    logic          i2s_ready = 1'b0;
    logic [31:0]   sample_out;
    logic          sample_valid;
    logic          busy;
    logic          clip;
    logic          overrun;

    int n_chk = 0;
    int n_err = 0;

    voice_mixer #(.NVOICES(NV), .GAIN_W(8), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .voices_in(voices_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain),
        .cfg_pan(cfg_pan), .i2s_ready(i2s_ready),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .clip(clip), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lr(input int l, input int r);
        return {l[15:0], r[15:0]};
    endfunction

    function automatic logic [31:0] exp_lr(input int mono, input int pl,
                                           input int pr);
`ifdef MIXER_PAN_EN
        return lr(pl, pr);
`else
        return lr(mono, mono);
`endif
    endfunction

    function automatic logic [63:0] pack4(input int a, input int b,
                                          input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic cfg(input int a, input int g, input int pn);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_gain = 8'(g);
        cfg_pan  = 8'(pn);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // act 0: plain frame, 1: cfg writes mid-MAC, 2: second edge while busy
    task automatic run_frame(input int act, output int lat, output int nval,
                             output int novr, output logic [31:0] so,
                             output logic clp);
        lat  = -1;
        nval = 0;
        novr = 0;
        so   = 'x;
        clp  = 1'bx;
        @(negedge clk);
        i2s_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                nval++;
                if (lat < 0) begin
                    lat = c;
                    so  = sample_out;
                    clp = clip;
                end
            end
            if (overrun) novr++;
            if (act == 1) begin
                if (c == 2) begin
                    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_gain = 8'd0;
                end else if (c == 3) begin
                    cfg_addr = 4'd4; cfg_gain = 8'd200;
                end else if (c == 4) begin
                    cfg_we = 1'b0;
                end
            end
            if (act == 2) begin
                if (c == 1) i2s_ready = 1'b0;
                if (c == 2) voices_in = pack4(2000, 0, 0, 0);
                if (c == 3) i2s_ready = 1'b1;
            end
        end
        i2s_ready = 1'b0;
    endtask

    int          lat, nval, novr;
    logic [31:0] so;
    logic        clp;

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out", sample_out, 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_clip", 32'(clip), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);

        // unity gain, other voices muted by gain 0
        voices_in = pack4(1000, 4321, -9999, 12345);
        cfg(0, 128, 128);
        run_frame(0, lat, nval, novr, so, clp);
        chk("t2_lat", 32'(lat), 32'(NV + 3));
        chk("t2_nval", 32'(nval), 32'd1);
        chk("t2_out", so, exp_lr(1000, 500, 500));
        chk("t2_clip", 32'(clp), 32'h0);
        chk("t2_ovr", 32'(novr), 32'h0);

        // pan 0: full left in pan build, ignored in mono build
        cfg(0, 128, 0);
        run_frame(0, lat, nval, novr, so, clp);
        chk("t6_out", so, exp_lr(1000, 1000, 0));

        // mixed gains, negative rounding toward -inf
        voices_in = pack4(1000, -200, 300, -7);
        cfg(0, 128, 128);
        cfg(1, 64, 128);
        cfg(2, 255, 128);
        cfg(3, 1, 128);
        run_frame(0, lat, nval, novr, so, clp);
        chk("mix_out", so, exp_lr(1496, 747, 747));
        chk("mix_clip", 32'(clp), 32'h0);

        // positive and negative saturation
        voices_in = pack4(30000, 30000, 30000, 30000);
        for (int v = 0; v < NV; v++) cfg(v, 255, 0);
        run_frame(0, lat, nval, novr, so, clp);
        chk("t3p_out", so, exp_lr(32767, 32767, 0));
        chk("t3p_clip", 32'(clp), 32'h1);
        voices_in = pack4(-30000, -30000, -30000, -30000);
        run_frame(0, lat, nval, novr, so, clp);
        chk("t3n_out", so, exp_lr(-32768, -32768, 0));
        chk("t3n_clip", 32'(clp), 32'h1);

        // overrun: second edge while busy, inputs changed after snapshot
        voices_in = pack4(1000, 0, 0, 0);
        cfg(0, 128, 128);
        for (int v = 1; v < NV; v++) cfg(v, 0, 128);
        run_frame(2, lat, nval, novr, so, clp);
        chk("t4_ovr", 32'(novr), 32'd1);
        chk("t4_nval", 32'(nval), 32'd1);
        chk("t4_lat", 32'(lat), 32'(NV + 3));
        chk("t4_out", so, exp_lr(1000, 500, 500));

        // reset mid-MAC
        voices_in = pack4(1000, 0, 0, 0);
        @(negedge clk);
        i2s_ready = 1'b1;
        repeat (3) @(negedge clk);
        i2s_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_out", sample_out, 32'h0);
        chk("t1_valid", 32'(sample_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sample_valid) nval++;
        end
        chk("t1_noval", 32'(nval), 32'h0);
        cfg(0, 128, 128);
        run_frame(0, lat, nval, novr, so, clp);
        chk("t1_lat", 32'(lat), 32'(NV + 3));
        chk("t1_out2", so, exp_lr(1000, 500, 500));

        // cfg mid-frame: old gain this frame, new gain next; addr 4 ignored
        run_frame(1, lat, nval, novr, so, clp);
        chk("t5_cur", so, exp_lr(1000, 500, 500));
        run_frame(0, lat, nval, novr, so, clp);
        chk("t5_next", so, exp_lr(0, 0, 0));
        chk("t5_nval", 32'(nval), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
